coin_dispenser: RTL and testbench
=================================

Name: coin_dispenser

Overview:
- Sequential back end of the change path: consumes the change decision (FirstCoin, SecondCoin, flags) and physically ejects coins, one per handshake, to the coin mechanism.
- Owns the Pentagons/Triangles/Circles inventory registers that feed the change maker.
- Reports the dispensed value and Done/Fault status to the vending controller.

Parameters:
- ACK_TIMEOUT, 15: maximum cycles EjectValid may stay high without EjectAck before a Fault abort (range 1..255).

Ports:
- clock  in  1  system clock
- reset_L  in  1  synchronous, active-low reset
- Start  in  1  one-cycle request; latches the change decision
- FirstCoin  in  3  coin code from the change maker
- SecondCoin  in  3  coin code from the change maker
- ExactAmount  in  1  no change required
- NotEnoughChange  in  1  change cannot be made
- CoughUpMore  in  1  payment is insufficient
- LoadInv  in  1  load the inventory from the Init* inputs
- InitPentagons  in  2  inventory load value
- InitTriangles  in  2  inventory load value
- InitCircles  in  2  inventory load value
- EjectAck  in  1  mechanism accepted the current coin
- Pentagons  out  2  current inventory
- Triangles  out  2  current inventory
- Circles  out  2  current inventory
- Eject  out  3  coin code being ejected; COIN_NONE when idle
- EjectValid  out  1  Eject is valid; held until EjectAck
- DispensedValue  out  4  sum of the values of coins ejected for the current request
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle pulse on successful completion
- Rejected  out  1  one-cycle pulse when Start arrives with CoughUpMore or NotEnoughChange set
- Fault  out  1  one-cycle pulse on timeout, empty inventory, or illegal code

Behaviour:
- Coin codes equal their value: COIN_NONE=0, CIRCLE=1, TRIANGLE=3, PENTAGON=5. Codes 2, 4, 6 and 7 are illegal.
- Reset (reset_L=0 at a clock edge):
  - state IDLE
  - inventory 0
  - Eject=0, EjectValid=0, DispensedValue=0
  - Busy, Done, Rejected, Fault all 0
  - the timeout counter is cleared
- Reset mid-ejection aborts immediately; no Done or Fault pulse is produced.
- States: IDLE, EJECT1, EJECT2, DONE.
- IDLE:
  - LoadInv=1: inventory <= Init* on the next edge. If Start is also high in the same cycle, Start is dropped and produces no pulse.
  - Start=1 and LoadInv=0: latch both coin codes and clear DispensedValue. Then branch on the latched request:
    - CoughUpMore or NotEnoughChange: Rejected pulses next cycle; stay in IDLE.
    - ExactAmount, or both codes COIN_NONE: go to DONE.
    - Otherwise go to EJECT1 if the first code is not NONE, else EJECT2.
  - Start and LoadInv are ignored in all states other than IDLE.
- EJECT1 / EJECT2:
  - EjectValid=1; Eject = the latched code.
  - An illegal code, or a zero inventory count for that coin, is detected on state entry. In that case EjectValid is not asserted, Fault pulses, and the state returns to IDLE.
  - On EjectAck: the matching count decrements by 1 and DispensedValue += code (4-bit).
  - After the ack, EJECT1 moves to EJECT2 if the second code is not NONE, else to DONE. EJECT2 moves to DONE.
  - Transfer rule: one coin per EjectValid&EjectAck cycle. EjectValid drops for at least one cycle between coins.
  - Timeout counter: cleared on state entry, increments each cycle without an ack. When it reaches ACK_TIMEOUT, Fault pulses, the state goes to IDLE, and inventory for the un-acked coin is unchanged.
  - EjectAck while EjectValid=0 is ignored.
- DONE: Done=1 for one cycle, then IDLE. DispensedValue holds until the next accepted Start.
- Latency: for an n-coin request with an immediate ack, Done is asserted 2n+2 cycles after Start (n=0 → 2).
- Inventory never wraps: a decrement from 0 cannot occur because of the empty check.

Decomposition:
- Package change_pkg holds:
  - coin_t (3-bit) and the COIN_* constants
  - state enum dispense_state_t
  - function coin_value() for width-safe addition
- Sub-module inventory_regs: the three 2-bit counters with load and a per-coin decrement. It has one natural boundary and the FSM drives its decrement enables.

Test Plan:
1. Reset, LoadInv with 3/3/3, Start with First=PENTAGON, Second=CIRCLE, ack the cycle after each EjectValid:
   - Eject 5, then 1
   - Pentagons=2, Circles=2, DispensedValue=6
   - Done 6 cycles after Start
2. Start with ExactAmount=1 → no EjectValid, Done after 2 cycles, DispensedValue=0.
3. Start with CoughUpMore=1 (and separately NotEnoughChange=1) → Rejected pulse only; Busy stays 0.
4. Inventory Triangles=0, Start with First=TRIANGLE → Fault pulse, EjectValid never high, inventory unchanged.
5. ACK_TIMEOUT=15 with no EjectAck → Fault on cycle 15 of EJECT1, IDLE next, counts unchanged. Then a fresh Start succeeds.
6. reset_L low during EJECT2 → IDLE with all outputs at reset values and inventory 0. Start/LoadInv pulsed while Busy have no effect.

Source files
------------

// File: rtl/change_pkg.sv
// Shared coin codes, dispenser states and coin helpers for the change path.
package change_pkg;

  typedef logic [2:0] coin_t;

  localparam coin_t COIN_NONE     = 3'd0;
  localparam coin_t COIN_CIRCLE   = 3'd1;
  localparam coin_t COIN_TRIANGLE = 3'd3;
  localparam coin_t COIN_PENTAGON = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EJECT1 = 2'd1,
    ST_EJECT2 = 2'd2,
    ST_DONE   = 2'd3
  } dispense_state_t;

  // A coin's code is its value; widen so sums of two coins cannot overflow.
  function automatic logic [3:0] coin_value(input coin_t c);
    return {1'b0, c};
  endfunction

  function automatic logic coin_is_real(input coin_t c);
    return (c == COIN_CIRCLE) || (c == COIN_TRIANGLE) || (c == COIN_PENTAGON);
  endfunction

endpackage

// File: rtl/inventory_regs.sv
// Three 2-bit coin counters with parallel load and per-coin decrement.
module inventory_regs
  import change_pkg::*;
(
  input  logic       clock,
  input  logic       reset_L,
  input  logic       load_i,
  input  logic [1:0] init_pent_i,
  input  logic [1:0] init_tri_i,
  input  logic [1:0] init_circ_i,
  input  logic       dec_pent_i,
  input  logic       dec_tri_i,
  input  logic       dec_circ_i,
  output logic [1:0] pent_o,
  output logic [1:0] tri_o,
  output logic [1:0] circ_o
);

  logic [1:0] pent_q, tri_q, circ_q;

  // Decrements are guarded so a count can never wrap below zero.
  always_ff @(posedge clock) begin
    if (!reset_L) begin
      pent_q <= 2'd0;
      tri_q  <= 2'd0;
      circ_q <= 2'd0;
    end else if (load_i) begin
      pent_q <= init_pent_i;
      tri_q  <= init_tri_i;
      circ_q <= init_circ_i;
    end else begin
      if (dec_pent_i && (pent_q != 2'd0)) pent_q <= pent_q - 2'd1;
      if (dec_tri_i  && (tri_q  != 2'd0)) tri_q  <= tri_q  - 2'd1;
      if (dec_circ_i && (circ_q != 2'd0)) circ_q <= circ_q - 2'd1;
    end
  end

  assign pent_o = pent_q;
  assign tri_o  = tri_q;
  assign circ_o = circ_q;

endmodule

// File: rtl/coin_dispenser.sv
// Ejects the change decision one coin per handshake and owns the coin inventory.
module coin_dispenser
  import change_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       Start,
  input  logic [2:0] FirstCoin,
  input  logic [2:0] SecondCoin,
  input  logic       ExactAmount,
  input  logic       NotEnoughChange,
  input  logic       CoughUpMore,
  input  logic       LoadInv,
  input  logic [1:0] InitPentagons,
  input  logic [1:0] InitTriangles,
  input  logic [1:0] InitCircles,
  input  logic       EjectAck,
  output logic [1:0] Pentagons,
  output logic [1:0] Triangles,
  output logic [1:0] Circles,
  output logic [2:0] Eject,
  output logic       EjectValid,
  output logic [3:0] DispensedValue,
  output logic       Busy,
  output logic       Done,
  output logic       Rejected,
  output logic       Fault
);

  dispense_state_t state_q, state_d;
  coin_t           first_q, first_d, second_q, second_d, eject_q, eject_d;
  logic            valid_q, valid_d;
  logic [3:0]      disp_q, disp_d;
  logic [7:0]      cnt_q, cnt_d, cnt_inc;
  logic            done_q, done_d, rej_q, rej_d, fault_q, fault_d;
  logic            load, dec_pent, dec_tri, dec_circ;
  coin_t           cur_code;
  logic [1:0]      cur_count;

  inventory_regs u_inv (
    .clock       (clock),
    .reset_L     (reset_L),
    .load_i      (load),
    .init_pent_i (InitPentagons),
    .init_tri_i  (InitTriangles),
    .init_circ_i (InitCircles),
    .dec_pent_i  (dec_pent),
    .dec_tri_i   (dec_tri),
    .dec_circ_i  (dec_circ),
    .pent_o      (Pentagons),
    .tri_o       (Triangles),
    .circ_o      (Circles)
  );

  always_comb begin
    cur_code  = (state_q == ST_EJECT2) ? second_q : first_q;
    cur_count = 2'd0;
    case (cur_code)
      COIN_CIRCLE:   cur_count = Circles;
      COIN_TRIANGLE: cur_count = Triangles;
      COIN_PENTAGON: cur_count = Pentagons;
      default:       cur_count = 2'd0;
    endcase
  end

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    first_d  = first_q;
    second_d = second_q;
    eject_d  = eject_q;
    valid_d  = valid_q;
    disp_d   = disp_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    rej_d    = 1'b0;
    fault_d  = 1'b0;
    load     = 1'b0;
    dec_pent = 1'b0;
    dec_tri  = 1'b0;
    dec_circ = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 8'd0;
        if (LoadInv) begin
          load = 1'b1;
        end else if (Start) begin
          first_d  = FirstCoin;
          second_d = SecondCoin;
          disp_d   = 4'd0;
          if (CoughUpMore || NotEnoughChange)
            rej_d = 1'b1;
          else if (ExactAmount || ((FirstCoin == COIN_NONE) && (SecondCoin == COIN_NONE)))
            state_d = ST_DONE;
          else if (FirstCoin != COIN_NONE)
            state_d = ST_EJECT1;
          else
            state_d = ST_EJECT2;
        end
      end
      ST_EJECT1, ST_EJECT2: begin
        // The entry cycle (valid low) validates the coin before offering it.
        if (!valid_q && (!coin_is_real(cur_code) || (cur_count == 2'd0))) begin
          fault_d = 1'b1;
          state_d = ST_IDLE;
        end else if (valid_q && EjectAck) begin
          valid_d  = 1'b0;
          eject_d  = COIN_NONE;
          cnt_d    = 8'd0;
          disp_d   = disp_q + coin_value(cur_code);
          dec_pent = (cur_code == COIN_PENTAGON);
          dec_tri  = (cur_code == COIN_TRIANGLE);
          dec_circ = (cur_code == COIN_CIRCLE);
          if ((state_q == ST_EJECT1) && (second_q != COIN_NONE))
            state_d = ST_EJECT2;
          else
            state_d = ST_DONE;
        end else if (cnt_inc == 8'(ACK_TIMEOUT)) begin
          fault_d = 1'b1;
          valid_d = 1'b0;
          eject_d = COIN_NONE;
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_inc;
          valid_d = 1'b1;
          eject_d = cur_code;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_L) begin
      state_q  <= ST_IDLE;
      first_q  <= COIN_NONE;
      second_q <= COIN_NONE;
      eject_q  <= COIN_NONE;
      valid_q  <= 1'b0;
      disp_q   <= 4'd0;
      cnt_q    <= 8'd0;
      done_q   <= 1'b0;
      rej_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      first_q  <= first_d;
      second_q <= second_d;
      eject_q  <= eject_d;
      valid_q  <= valid_d;
      disp_q   <= disp_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      rej_q    <= rej_d;
      fault_q  <= fault_d;
    end
  end

  assign Eject          = eject_q;
  assign EjectValid     = valid_q;
  assign DispensedValue = disp_q;
  assign Busy           = (state_q != ST_IDLE);
  assign Done           = done_q;
  assign Rejected       = rej_q;
  assign Fault          = fault_q;

endmodule

// File: tb/tb_coin_dispenser.sv
// Directed self-checking bench for coin_dispenser.
module tb_coin_dispenser;

  logic       clock = 1'b0;
  logic       reset_L, Start, ExactAmount, NotEnoughChange, CoughUpMore, LoadInv, EjectAck;
  logic [2:0] FirstCoin, SecondCoin;
  logic [1:0] InitPentagons, InitTriangles, InitCircles;
  logic [1:0] Pentagons, Triangles, Circles;
  logic [2:0] Eject;
  logic       EjectValid, Busy, Done, Rejected, Fault;
  logic [3:0] DispensedValue;

  int checks = 0;
  int errors = 0;
  logic seen_bad;

  coin_dispenser #(.ACK_TIMEOUT(15)) dut (
    .clock          (clock),
    .reset_L        (reset_L),
    .Start          (Start),
    .FirstCoin      (FirstCoin),
    .SecondCoin     (SecondCoin),
    .ExactAmount    (ExactAmount),
    .NotEnoughChange(NotEnoughChange),
    .CoughUpMore    (CoughUpMore),
    .LoadInv        (LoadInv),
    .InitPentagons  (InitPentagons),
    .InitTriangles  (InitTriangles),
    .InitCircles    (InitCircles),
    .EjectAck       (EjectAck),
    .Pentagons      (Pentagons),
    .Triangles      (Triangles),
    .Circles        (Circles),
    .Eject          (Eject),
    .EjectValid     (EjectValid),
    .DispensedValue (DispensedValue),
    .Busy           (Busy),
    .Done           (Done),
    .Rejected       (Rejected),
    .Fault          (Fault)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_inv(input logic [1:0] p, input logic [1:0] t, input logic [1:0] c);
    LoadInv = 1'b1; InitPentagons = p; InitTriangles = t; InitCircles = c;
    step();
    LoadInv = 1'b0;
  endtask

  initial begin
    reset_L = 1'b0; Start = 1'b0; ExactAmount = 1'b0; NotEnoughChange = 1'b0;
    CoughUpMore = 1'b0; LoadInv = 1'b0; EjectAck = 1'b0;
    FirstCoin = 3'd0; SecondCoin = 3'd0;
    InitPentagons = 2'd0; InitTriangles = 2'd0; InitCircles = 2'd0;
    step(); step();
    check("rst_pent", 8'(Pentagons), 8'd0);
    check("rst_circ", 8'(Circles), 8'd0);
    check("rst_eject", 8'(Eject), 8'd0);
    check("rst_valid", 8'(EjectValid), 8'd0);
    check("rst_disp", 8'(DispensedValue), 8'd0);
    check("rst_busy", 8'(Busy), 8'd0);
    check("rst_pulses", {5'd0, Done, Rejected, Fault}, 8'd0);
    reset_L = 1'b1;

    // Two-coin request, ack as soon as each coin is offered
    load_inv(2'd3, 2'd3, 2'd3);
    check("load_pent", 8'(Pentagons), 8'd3);
    check("load_tri", 8'(Triangles), 8'd3);
    FirstCoin = 3'd5; SecondCoin = 3'd1; Start = 1'b1;
    step(); Start = 1'b0;                                   // cycle 1
    check("t1_busy", 8'(Busy), 8'd1);
    check("t1_entry_valid", 8'(EjectValid), 8'd0);
    step();                                                 // cycle 2
    check("t1_valid1", 8'(EjectValid), 8'd1);
    check("t1_eject1", 8'(Eject), 8'd5);
    EjectAck = 1'b1; step(); EjectAck = 1'b0;               // cycle 3
    check("t1_gap", 8'(EjectValid), 8'd0);
    check("t1_pent", 8'(Pentagons), 8'd2);
    check("t1_disp1", 8'(DispensedValue), 8'd5);
    step();                                                 // cycle 4
    check("t1_valid2", 8'(EjectValid), 8'd1);
    check("t1_eject2", 8'(Eject), 8'd1);
    EjectAck = 1'b1; step(); EjectAck = 1'b0;               // cycle 5
    check("t1_circ", 8'(Circles), 8'd2);
    check("t1_disp2", 8'(DispensedValue), 8'd6);
    check("t1_done_early", 8'(Done), 8'd0);
    step();                                                 // cycle 6
    check("t1_done", 8'(Done), 8'd1);
    check("t1_busy_end", 8'(Busy), 8'd0);
    step();
    check("t1_done_pulse", 8'(Done), 8'd0);
    check("t1_disp_hold", 8'(DispensedValue), 8'd6);

    // Exact amount: nothing ejected, Done after two cycles
    ExactAmount = 1'b1; Start = 1'b1;
    step(); Start = 1'b0; ExactAmount = 1'b0;
    check("t2_valid", 8'(EjectValid), 8'd0);
    check("t2_disp", 8'(DispensedValue), 8'd0);
    check("t2_done_early", 8'(Done), 8'd0);
    step();
    check("t2_done", 8'(Done), 8'd1);
    check("t2_pent", 8'(Pentagons), 8'd2);

    // Rejections
    CoughUpMore = 1'b1; Start = 1'b1;
    step(); Start = 1'b0; CoughUpMore = 1'b0;
    check("t3_rej_cum", 8'(Rejected), 8'd1);
    check("t3_busy_cum", 8'(Busy), 8'd0);
    step();
    check("t3_rej_pulse", 8'(Rejected), 8'd0);
    NotEnoughChange = 1'b1; Start = 1'b1;
    step(); Start = 1'b0; NotEnoughChange = 1'b0;
    check("t3_rej_nec", 8'(Rejected), 8'd1);
    check("t3_busy_nec", 8'(Busy), 8'd0);
    step();

    // Empty inventory and illegal code both fault without offering a coin
    load_inv(2'd2, 2'd0, 2'd2);
    FirstCoin = 3'd3; SecondCoin = 3'd0; Start = 1'b1;
    step(); Start = 1'b0;
    check("t4_busy", 8'(Busy), 8'd1);
    check("t4_valid_a", 8'(EjectValid), 8'd0);
    step();
    check("t4_fault", 8'(Fault), 8'd1);
    check("t4_valid_b", 8'(EjectValid), 8'd0);
    check("t4_idle", 8'(Busy), 8'd0);
    check("t4_inv", {2'd0, Pentagons, Triangles, Circles}, {2'd0, 2'd2, 2'd0, 2'd2});
    step();
    check("t4_fault_pulse", 8'(Fault), 8'd0);
    FirstCoin = 3'd2; Start = 1'b1;
    step(); Start = 1'b0;
    step();
    check("t4_illegal_fault", 8'(Fault), 8'd1);
    check("t4_illegal_valid", 8'(EjectValid), 8'd0);

    // Ack timeout: 15 cycles in EJECT1, then IDLE with Fault and counts intact
    FirstCoin = 3'd5; SecondCoin = 3'd0; Start = 1'b1;
    step(); Start = 1'b0;                                   // cycle 1
    seen_bad = 1'b0;
    for (int i = 2; i <= 15; i++) begin
      step();
      if (!EjectValid || Fault || !Busy) seen_bad = 1'b1;
    end
    check("t5_hold_valid", 8'(seen_bad), 8'd0);
    step();                                                 // cycle 16
    check("t5_fault", 8'(Fault), 8'd1);
    check("t5_idle", 8'(Busy), 8'd0);
    check("t5_valid", 8'(EjectValid), 8'd0);
    check("t5_pent", 8'(Pentagons), 8'd2);
    Start = 1'b1;
    step(); Start = 1'b0;
    step();
    EjectAck = 1'b1; step(); EjectAck = 1'b0;
    check("t5_retry_disp", 8'(DispensedValue), 8'd5);
    step();
    check("t5_retry_done", 8'(Done), 8'd1);
    check("t5_retry_pent", 8'(Pentagons), 8'd1);

    // Busy ignores Start/LoadInv; reset in EJECT2 aborts cleanly
    load_inv(2'd3, 2'd3, 2'd3);
    FirstCoin = 3'd1; SecondCoin = 3'd3; Start = 1'b1;
    step(); Start = 1'b0;
    step();
    EjectAck = 1'b1; step(); EjectAck = 1'b0;
    LoadInv = 1'b1; InitPentagons = 2'd0; InitTriangles = 2'd0; InitCircles = 2'd0; Start = 1'b1;
    step(); LoadInv = 1'b0; Start = 1'b0;
    check("t6_eject2", 8'(Eject), 8'd3);
    check("t6_noload", {4'd0, Pentagons, Circles}, {4'd0, 2'd3, 2'd2});
    reset_L = 1'b0;
    step(); reset_L = 1'b1;
    check("t6_rst_busy", 8'(Busy), 8'd0);
    check("t6_rst_out", {EjectValid, Eject, DispensedValue}, 8'd0);
    check("t6_rst_inv", {2'd0, Pentagons, Triangles, Circles}, 8'd0);
    step();
    check("t6_no_pulse", {5'd0, Done, Rejected, Fault}, 8'd0);

    // LoadInv and Start together: load wins, Start dropped
    FirstCoin = 3'd1; SecondCoin = 3'd0; Start = 1'b1;
    load_inv(2'd1, 2'd1, 2'd1);
    Start = 1'b0;
    check("t6_load_start_busy", 8'(Busy), 8'd0);
    check("t6_load_start_inv", 8'(Circles), 8'd1);
    step();
    check("t6_load_start_pulse", {5'd0, Done, Rejected, Fault}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
